// File: rtl/rd_code_builder.sv
// Relative-difference code builder: compares successive ring sums of one pixel
// and packs the comparison bits into a code word, with length checking.
module rd_code_builder #(
    parameter int unsigned SUM_WIDTH = 24,
    parameter int unsigned NUM_RINGS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SUM_WIDTH-1:0]   sum_i,
    input  logic                   sum_valid_i,
    input  logic                   sum_last_i,
    input  logic                   mode_i,
    input  logic [SUM_WIDTH-1:0]   thr_i,
    input  logic                   done_i,
    output logic [NUM_RINGS-2:0]   code_o,
    output logic                   code_valid_o,
    output logic                   len_err_o,
    output logic                   done_o
);

    localparam int unsigned NB = NUM_RINGS - 1;
    localparam int unsigned CW = (NUM_RINGS > 2) ? $clog2(NUM_RINGS) : 1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0]   prev_q, prev_d;
    logic [NB-1:0]          shift_q, shift_d;
    logic                   mode_q, mode_d;
    logic [SUM_WIDTH-1:0]   thr_q, thr_d;
    logic [NB-1:0]          code_q, code_d;
    logic                   code_valid_q, code_valid_d;
    logic                   len_err_q, len_err_d;
    logic                   done_q;

    logic [SUM_WIDTH:0]     cmp_lhs, cmp_rhs;
    logic                   cmp_bit;
    logic [NB-1:0]          shifted;

    // One extra bit keeps prev + thr from wrapping.
    always_comb begin
        cmp_lhs = {1'b0, sum_i};
        cmp_rhs = {1'b0, prev_q} + (mode_q ? {1'b0, thr_q} : '0);
        cmp_bit = (cmp_lhs >= cmp_rhs);
        shifted = NB'({shift_q, cmp_bit});
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        shift_d      = shift_q;
        mode_d       = mode_q;
        thr_d        = thr_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        len_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sum_valid_i) begin
                    if (sum_last_i) begin
                        len_err_d = 1'b1;
                    end else begin
                        prev_d  = sum_i;
                        cnt_d   = CW'(1);
                        shift_d = '0;
                        mode_d  = mode_i;
                        thr_d   = thr_i;
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (sum_valid_i) begin
                    if (sum_last_i) begin
                        if (cnt_q == CW'(NB)) begin
                            code_d       = shifted;
                            code_valid_d = 1'b1;
                        end else begin
                            len_err_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == CW'(NB)) begin
                        len_err_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        shift_d = shifted;
                        prev_d  = sum_i;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prev_q       <= '0;
            shift_q      <= '0;
            mode_q       <= 1'b0;
            thr_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            len_err_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            shift_q      <= shift_d;
            mode_q       <= mode_d;
            thr_q        <= thr_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            len_err_q    <= len_err_d;
            done_q       <= done_i;
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = code_valid_q;
    assign len_err_o    = len_err_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_rd_code_builder.sv
// Directed bench for rd_code_builder with hand-computed expected codes.
module tb_rd_code_builder;

    logic        clk;
    logic        rst;
    logic [23:0] sum_i;
    logic        sum_valid_i;
    logic        sum_last_i;
    logic        mode_i;
    logic [23:0] thr_i;
    logic        done_i;
    logic [2:0]  code_o;
    logic        code_valid_o;
    logic        len_err_o;
    logic        done_o;

    int unsigned vectors;
    int unsigned miscompares;

    rd_code_builder #(.SUM_WIDTH(24), .NUM_RINGS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sum_i        (sum_i),
        .sum_valid_i  (sum_valid_i),
        .sum_last_i   (sum_last_i),
        .mode_i       (mode_i),
        .thr_i        (thr_i),
        .done_i       (done_i),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .len_err_o    (len_err_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic l, input logic [23:0] s);
        sum_valid_i = v;
        sum_last_i  = l;
        sum_i       = s;
        @(posedge clk);
        #1;
        sum_valid_i = 1'b0;
        sum_last_i  = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [2:0] code, input logic cv, input logic le);
        check({tag, ".code"}, {29'd0, code_o}, {29'd0, code});
        check({tag, ".cv"}, {31'd0, code_valid_o}, {31'd0, cv});
        check({tag, ".le"}, {31'd0, len_err_o}, {31'd0, le});
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        sum_i = '0;
        sum_valid_i = 1'b0;
        sum_last_i = 1'b0;
        mode_i = 1'b0;
        thr_i = '0;
        done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs("reset", 3'b000, 1'b0, 1'b0);
        check("reset.done", {31'd0, done_o}, 32'd0);
        rst = 1'b1;
        step(0, 0, 0);

        // plain compare 100,150,150,90 -> 110
        mode_i = 1'b0;
        step(1, 0, 24'd100); step(1, 0, 24'd150); step(1, 0, 24'd150);
        outs("plain.mid", 3'b000, 1'b0, 1'b0);
        step(1, 1, 24'd90);
        outs("plain", 3'b110, 1'b1, 1'b0);
        step(0, 0, 0);
        outs("plain.after", 3'b110, 1'b0, 1'b0);

        // tolerance thr=20: 100,130,140,200 -> 101
        mode_i = 1'b1; thr_i = 24'd20;
        step(1, 0, 24'd100); step(1, 0, 24'd130); step(1, 0, 24'd140);
        step(1, 1, 24'd200);
        outs("tol", 3'b101, 1'b1, 1'b0);

        // overflow guard -> 000
        thr_i = 24'hFFFFFF;
        step(1, 0, 24'hFFFFF0); step(1, 0, 24'hFFFFFF); step(1, 0, 24'd0);
        step(1, 1, 24'd0);
        outs("ovf", 3'b000, 1'b1, 1'b0);

        // short pixel then 1,2,3,4 -> 111
        mode_i = 1'b0; thr_i = 24'd0;
        step(1, 0, 24'd5); step(1, 0, 24'd6); step(1, 1, 24'd7);
        outs("short", 3'b000, 1'b0, 1'b1);
        step(0, 0, 0);
        outs("short.after", 3'b000, 1'b0, 1'b0);
        step(1, 0, 24'd1); step(1, 0, 24'd2); step(1, 0, 24'd3);
        step(1, 1, 24'd4);
        outs("incr", 3'b111, 1'b1, 1'b0);

        // long pixel, then extra sums start a new pixel 9,8,7,6 -> 000
        step(1, 0, 24'd1); step(1, 0, 24'd2); step(1, 0, 24'd3);
        step(1, 0, 24'd4);
        outs("long", 3'b111, 1'b0, 1'b1);
        step(1, 0, 24'd9); step(1, 0, 24'd8); step(1, 0, 24'd7);
        step(1, 1, 24'd6);
        outs("newpix", 3'b000, 1'b1, 1'b0);

        // single-ring pixel
        step(1, 1, 24'd42);
        outs("single", 3'b000, 1'b0, 1'b1);

        // mode/thr change mid-pixel is ignored: plain 10,20,30,40 -> 111
        mode_i = 1'b0;
        step(1, 0, 24'd10);
        mode_i = 1'b1; thr_i = 24'd100;
        step(1, 0, 24'd20); step(1, 0, 24'd30);
        step(1, 1, 24'd40);
        outs("latch", 3'b111, 1'b1, 1'b0);
        mode_i = 1'b0; thr_i = 24'd0;

        // back-to-back streaming
        step(1, 0, 24'd100); step(1, 0, 24'd150); step(1, 0, 24'd150);
        step(1, 1, 24'd90);
        outs("strm.a", 3'b110, 1'b1, 1'b0);
        step(1, 0, 24'd1);
        outs("strm.b1", 3'b110, 1'b0, 1'b0);
        step(1, 0, 24'd2); step(1, 0, 24'd3);
        step(1, 1, 24'd4);
        outs("strm.b", 3'b111, 1'b1, 1'b0);

        // same pixels with 3-cycle gaps
        step(1, 0, 24'd100); repeat (3) step(0, 0, 0);
        step(1, 0, 24'd150); repeat (3) step(0, 0, 0);
        step(1, 0, 24'd150); repeat (3) step(0, 0, 0);
        step(1, 1, 24'd90);
        outs("gap.a", 3'b110, 1'b1, 1'b0);
        repeat (3) step(0, 0, 0);
        step(1, 0, 24'd1); repeat (3) step(0, 0, 0);
        step(1, 0, 24'd2); repeat (3) step(0, 0, 0);
        step(1, 0, 24'd3);
        outs("gap.b3", 3'b110, 1'b0, 1'b0);
        repeat (3) step(0, 0, 0);
        step(1, 1, 24'd4);
        outs("gap.b", 3'b111, 1'b1, 1'b0);

        // reset mid-pixel, then a clean pixel
        step(1, 0, 24'd100); step(1, 0, 24'd50);
        rst = 1'b0;
        #1;
        outs("rstmid", 3'b000, 1'b0, 1'b0);
        step(0, 0, 0);
        outs("rstmid.hold", 3'b000, 1'b0, 1'b0);
        rst = 1'b1;
        step(1, 0, 24'd100); step(1, 0, 24'd150); step(1, 0, 24'd150);
        outs("rstmid.partial", 3'b000, 1'b0, 1'b0);
        step(1, 1, 24'd90);
        outs("rstmid.full", 3'b110, 1'b1, 1'b0);

        // done pass-through
        done_i = 1'b1;
        #1;
        check("done.pre", {31'd0, done_o}, 32'd0);
        step(0, 0, 0);
        done_i = 1'b0;
        check("done.pulse", {31'd0, done_o}, 32'd1);
        step(0, 0, 0);
        check("done.clear", {31'd0, done_o}, 32'd0);

        // done on final ring coincides with code_valid_o
        step(1, 0, 24'd3); step(1, 0, 24'd2); step(1, 0, 24'd1);
        done_i = 1'b1;
        step(1, 1, 24'd5);
        done_i = 1'b0;
        outs("donelast", 3'b001, 1'b1, 1'b0);
        check("donelast.done", {31'd0, done_o}, 32'd1);
        step(0, 0, 0);
        check("donelast.clear", {31'd0, done_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rd_code_builder.md
# rd_code_builder

Parametrised successor to the single-pair relative-difference comparator in the NIRD path. Takes a stream of ring sums for one pixel, innermost first, one sum per accepted cycle. Compares each ring against the previous one and packs the resulting NUM_RINGS-1 bits into a code word. Adds an optional tolerance mode, per-pixel length checking and a registered done pass-through, and feeds the NIRD code histogram stage.

## Interface
- SUM_WIDTH, 24, width of each ring sum and of the tolerance input
- NUM_RINGS, 4, rings per pixel (≥ 2); code width NB = NUM_RINGS-1

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- sum_i  in  SUM_WIDTH  ring sum, unsigned
- sum_valid_i  in  1  sum_i valid this cycle
- sum_last_i  in  1  qualifies sum_valid_i; marks outermost ring of pixel
- mode_i  in  1  0 = plain compare, 1 = tolerance compare
- thr_i  in  SUM_WIDTH  tolerance, unsigned
- done_i  in  1  frame-done strobe from upstream
- code_o  out  NB  packed relative-difference code, first comparison in MSB
- code_valid_o  out  1  one-cycle pulse, code_o new
- len_err_o  out  1  one-cycle pulse, pixel dropped for wrong ring count
- done_o  out  1  done_i delayed one cycle

## Operation
- State: IDLE (ring count 0) and ACC (ring count 1..NUM_RINGS-1).
- Registers: prev (SUM_WIDTH), cnt, shift code (NB), latched mode/thr.
- IDLE, sum_valid_i=1, sum_last_i=0:
  - prev ← sum_i, cnt ← 1, shift code ← 0.
  - Latch mode_i/thr_i for the whole pixel.
  - Go to ACC.
- IDLE, sum_valid_i=1, sum_last_i=1: single-ring pixel. Pulse len_err_o, stay IDLE.
- ACC, sum_valid_i=1:
  - bit = 1 if sum_i ≥ prev (mode 0); 1 if sum_i ≥ prev + thr (mode 1); else 0.
  - Compare width is SUM_WIDTH+1, zero-extended. Addition never wraps.
  - Shift: code ← {code[NB-2:0], bit}; prev ← sum_i; cnt ← cnt+1.
- Terminating a pixel in ACC:
  - sum_last_i=1 and cnt==NUM_RINGS-1: code_o ← shifted code, pulse code_valid_o, go to IDLE.
  - sum_last_i=1 and cnt<NUM_RINGS-1: short pixel. Pulse len_err_o, discard, go to IDLE.
  - sum_last_i=0 and cnt==NUM_RINGS-1: long pixel. Pulse len_err_o, discard this sample and the pixel, go to IDLE.
  - Extra sums after a long pixel start a new pixel.
- sum_valid_i=0: all state holds. Gaps of any length are legal.
- code_o holds its last value until the next valid code. It is not changed by errors.
- done_o ← done_i every cycle, independent of state.
- No backpressure. Downstream must accept each code_valid_o pulse.

## Timing
- Reset (rst=0, async): all outputs 0, state IDLE, cnt 0, prev 0, code 0.
- Reset asserted mid-pixel discards the partial pixel. No pulse is generated.
- First accepted sample after reset release starts a new pixel.
- Latency: code_valid_o/len_err_o rise one cycle after the clock edge that accepts the terminating sample.
- done_o has the same latency. done_i on the final ring gives done_o coincident with code_valid_o.
- Throughput: one sum per cycle. Back-to-back pixels need no idle cycle: the cycle after a last sample may be the first ring of the next pixel.
- mode_i/thr_i changes mid-pixel have no effect until the next pixel start.

## Test plan
- Plain compare, mode=0, sums 100,150,150,90 (last on 90) -> code_o=3'b110, code_valid_o high one cycle after 90 accepted, len_err_o=0.
- Tolerance compare, mode=1, thr=20, sums 100,130,140,200 -> code_o=3'b101.
- Overflow guard, mode=1, thr=24'hFFFFFF, sums 24'hFFFFF0,24'hFFFFFF,0,0 -> code_o=3'b000. Confirms no wrap in prev+thr.
- Length errors:
  - Short: last on 3rd sample -> len_err_o pulse, no code_valid_o, code_o unchanged. A following 4-sum pixel 1,2,3,4 -> 3'b111.
  - Long: 4th sample without last -> len_err_o pulse.
- Streaming: 8 consecutive valid cycles (two pixels, last on samples 4 and 8) -> code_valid_o pulses on cycles 5 and 9. Same pixels with 3-cycle gaps between samples -> identical codes.
- Reset and done:
  - rst=0 after 2 samples of a pixel -> all outputs 0, no pulse. After release, a full pixel decodes correctly.
  - done_i pulse -> done_o pulse exactly one cycle later.
